// File: rtl/cpu_run_checker.sv
// cpu_run_checker
//   Drives one test run of a small CPU and grades the result. A run holds the
//   CPU in reset for RST_CYCLES, releases it and counts RUN cycles until it
//   halts (or until the MAX_CYCLES limit), reads one memory word through a
//   1-cycle-latency synchronous read port, and compares both the captured
//   accumulator and that word against expected values latched at start.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle request to begin a run (honoured in IDLE/DONE)
//   cpu_halt        CPU halt indication
//   cpu_acc         CPU accumulator value
//   chk_addr        memory address to check (latched at start)
//   exp_acc/exp_mem expected accumulator / memory word (latched at start)
//   mem_rd_data     read data, valid the cycle after mem_rd_addr
//   cpu_rst         reset to the CPU (low only in RUN)
//   mem_rd_addr     read address (latched chk_addr in READ/CHECK, else 0)
//   busy, done      run in progress / run finished
//   pass, timeout   run verdict
//   cycles          RUN-phase cycle count of the current or last run
module cpu_run_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 100,
    parameter int HALT_MODE  = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cpu_halt,
    input  logic [DATA_WIDTH-1:0] cpu_acc,
    input  logic [ADDR_WIDTH-1:0] chk_addr,
    input  logic [DATA_WIDTH-1:0] exp_acc,
    input  logic [DATA_WIDTH-1:0] exp_mem,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  cpu_rst,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  cycles
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RW-1:0]        RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] MAX_C    = CNT_WIDTH'(MAX_CYCLES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RESET = 3'd1,
        RUN   = 3'd2,
        READ  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [RW-1:0]         rst_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] exp_acc_q, exp_mem_q, acc_q;
    logic [CNT_WIDTH-1:0]  cyc_inc;
    logic                  capture, timed_out;

    // Count including the current RUN cycle; the limit test uses this value
    // so the run ends on the cycle that makes the count equal MAX_CYCLES.
    assign cyc_inc = cycles + CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        timed_out = 1'b0;
        unique case (state)
            IDLE, DONE: if (start) state_nxt = RESET;
            RESET:      if (rst_cnt == RST_LAST) state_nxt = RUN;
            RUN: begin
                // Halt is tested first so a halt on the limit cycle wins.
                if (HALT_MODE != 0 && cpu_halt) begin
                    state_nxt = READ;
                    capture   = 1'b1;
                end else if (cyc_inc == MAX_C) begin
                    if (HALT_MODE != 0) begin
                        state_nxt = DONE;
                        timed_out = 1'b1;
                    end else begin
                        state_nxt = READ;
                        capture   = 1'b1;
                    end
                end
            end
            READ:    state_nxt = CHECK;
            CHECK:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_cnt   <= '0;
            addr_q    <= '0;
            exp_acc_q <= '0;
            exp_mem_q <= '0;
            acc_q     <= '0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            cycles    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rst_cnt   <= '0;
                        addr_q    <= chk_addr;
                        exp_acc_q <= exp_acc;
                        exp_mem_q <= exp_mem;
                        pass      <= 1'b0;
                        timeout   <= 1'b0;
                        cycles    <= '0;
                    end
                end
                RESET: rst_cnt <= rst_cnt + RW'(1);
                RUN: begin
                    cycles <= cyc_inc;
                    if (capture) acc_q <= cpu_acc;
                    if (timed_out) begin
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                // Address was presented during READ, so the word is on
                // mem_rd_data now.
                CHECK: pass <= (acc_q == exp_acc_q) && (mem_rd_data == exp_mem_q);
                default: ;
            endcase
        end
    end

    assign cpu_rst     = (state != RUN);
    assign busy        = (state == RESET) || (state == RUN) ||
                         (state == READ)  || (state == CHECK);
    assign done        = (state == DONE);
    assign mem_rd_addr = ((state == READ) || (state == CHECK)) ? addr_q : '0;

endmodule

// File: tb/tb_cpu_run_checker.sv
module tb_cpu_run_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start0 = 1'b0, start1 = 1'b0;
    logic [4:0] chk_addr = '0;
    logic [7:0] exp_acc = '0, exp_mem = '0;
    logic [7:0] mem [32];
    logic [7:0] rd0, rd1;

    int         halt_at = 0;
    logic [7:0] seed = '0, step = '0;

    logic        cpu_rst0, busy0, done0, pass0, to0;
    logic        cpu_rst1, busy1, done1, pass1, to1;
    logic [4:0]  addr0, addr1;
    logic [15:0] cyc0, cyc1;

    // Toy CPUs: acc starts at seed when released and adds step per cycle,
    // k is the 1-based RUN cycle number; halt raised on cycle halt_at.
    int         k0, k1;
    logic [7:0] acc0, acc1;
    logic       halt0, halt1;
    always @(posedge clk) begin
        if (cpu_rst0) begin k0 <= 1; acc0 <= seed; end
        else          begin k0 <= k0 + 1; acc0 <= acc0 + step; end
        if (cpu_rst1) begin k1 <= 1; acc1 <= seed; end
        else          begin k1 <= k1 + 1; acc1 <= acc1 + step; end
        rd0 <= mem[addr0];
        rd1 <= mem[addr1];
    end
    assign halt0 = (halt_at > 0) && (k0 == halt_at);
    assign halt1 = (halt_at > 0) && (k1 == halt_at);

    cpu_run_checker dut0 (
        .clk(clk), .rst(rst), .start(start0), .cpu_halt(halt0), .cpu_acc(acc0),
        .chk_addr(chk_addr), .exp_acc(exp_acc), .exp_mem(exp_mem), .mem_rd_data(rd0),
        .cpu_rst(cpu_rst0), .mem_rd_addr(addr0), .busy(busy0), .done(done0),
        .pass(pass0), .timeout(to0), .cycles(cyc0)
    );

    cpu_run_checker #(.HALT_MODE(0), .MAX_CYCLES(20)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .cpu_halt(halt1), .cpu_acc(acc1),
        .chk_addr(chk_addr), .exp_acc(exp_acc), .exp_mem(exp_mem), .mem_rd_data(rd1),
        .cpu_rst(cpu_rst1), .mem_rd_addr(addr1), .busy(busy1), .done(done1),
        .pass(pass1), .timeout(to1), .cycles(cyc1)
    );

    logic        sel = 1'b0;
    logic        c_done, c_pass, c_to, c_busy, c_rst;
    logic [4:0]  c_addr;
    logic [15:0] c_cyc;
    assign c_done = sel ? done1 : done0;
    assign c_pass = sel ? pass1 : pass0;
    assign c_to   = sel ? to1 : to0;
    assign c_busy = sel ? busy1 : busy0;
    assign c_rst  = sel ? cpu_rst1 : cpu_rst0;
    assign c_addr = sel ? addr1 : addr0;
    assign c_cyc  = sel ? cyc1 : cyc0;

    int vectors = 0, miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic idle_chk(input string nm);
        chk({nm, ".cpu_rst"}, cpu_rst0, 1);
        chk({nm, ".rd_addr"}, addr0, 0);
        chk({nm, ".busy"}, busy0, 0);
        chk({nm, ".done"}, done0, 0);
        chk({nm, ".pass"}, pass0, 0);
        chk({nm, ".timeout"}, to0, 0);
        chk({nm, ".cycles"}, cyc0, 0);
    endtask

    task automatic set_start(input logic s, input logic v);
        if (s) start1 = v; else start0 = v;
    endtask

    // One complete run; inputs are scrambled after start to show they were latched.
    task automatic run(input logic s, input int h, input logic [7:0] sd, input logic [7:0] st,
                       input logic [4:0] a, input logic [7:0] memv, input logic [7:0] ea,
                       input logic [7:0] em, input bit xs, input int xc, input bit xp,
                       input bit xt, input string nm);
        int  n;
        bit  bad;
        @(negedge clk);
        sel = s; mem[a] = memv; halt_at = h; seed = sd; step = st;
        chk_addr = a; exp_acc = ea; exp_mem = em;
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        chk_addr = ~a; exp_acc = ~ea; exp_mem = ~em;
        n = 0; bad = 0;
        while (!c_done && n < 300) begin
            if (c_addr != 0 && (xt || c_addr != a)) bad = 1;
            set_start(s, xs && (n == 1 || n == 20 || n == 40));
            @(negedge clk);
            n++;
        end
        set_start(s, 1'b0);
        chk({nm, ".done"}, c_done, 1);
        chk({nm, ".busy"}, c_busy, 0);
        chk({nm, ".cpu_rst"}, c_rst, 1);
        chk({nm, ".cycles"}, c_cyc, xc);
        chk({nm, ".pass"}, c_pass, xp);
        chk({nm, ".timeout"}, c_to, xt);
        chk({nm, ".rd_addr"}, bad, 0);
        chk({nm, ".rd_addr_done"}, c_addr, 0);
    endtask

    typedef struct {
        int         h;
        logic [7:0] seed, step;
        logic [4:0] addr;
        logic [7:0] memv, eacc, emem;
        bit         xs;
        int         xc;
        bit         xp, xt;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int         n, h, xc;
        bit         xp, xt;
        logic [7:0] sd, st, memv, ea, em, acc_h;
        logic [4:0] a;

        tbl[0] = '{10,  8'h5A, 8'h00, 5'd7,  8'h3C, 8'h5A, 8'h3C, 0, 10,  1, 0};
        tbl[1] = '{10,  8'h5A, 8'h00, 5'd7,  8'h3D, 8'h5A, 8'h3C, 0, 10,  0, 0};
        tbl[2] = '{0,   8'h5A, 8'h01, 5'd7,  8'h3C, 8'h5A, 8'h3C, 0, 100, 0, 1};
        tbl[3] = '{100, 8'h0A, 8'h01, 5'd9,  8'hC3, 8'h6D, 8'hC3, 1, 100, 1, 0};
        tbl[4] = '{1,   8'h21, 8'h07, 5'd31, 8'h00, 8'h21, 8'h00, 0, 1,   1, 0};
        tbl[5] = '{50,  8'h00, 8'h02, 5'd3,  8'h77, 8'h63, 8'h77, 0, 50,  0, 0};
        tbl[6] = '{101, 8'h10, 8'h01, 5'd4,  8'h01, 8'h00, 8'h01, 0, 100, 0, 1};
        tbl[7] = '{99,  8'hF0, 8'h01, 5'd0,  8'hAA, 8'h52, 8'hAA, 0, 99,  1, 0};

        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        idle_chk("reset");
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run(0, tbl[i].h, tbl[i].seed, tbl[i].step, tbl[i].addr, tbl[i].memv,
                tbl[i].eacc, tbl[i].emem, tbl[i].xs, tbl[i].xc, tbl[i].xp, tbl[i].xt,
                $sformatf("vec%0d", i));

        // Limit-only mode: halt at 5 ignored, acc must come from cycle 20
        run(1, 5, 8'h11, 8'h03, 5'd12, 8'h99, 8'h4A, 8'h99, 0, 20, 1, 0, "fixed_ok");
        run(1, 5, 8'h11, 8'h03, 5'd12, 8'h99, 8'h1D, 8'h99, 0, 20, 0, 0, "fixed_early");

        // Mid-run reset, then a fresh run and its release latency
        @(negedge clk);
        sel = 0; halt_at = 0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (cyc0 != 16'd4 && n < 20) begin @(negedge clk); n++; end
        chk("midrst.reach4", cyc0, 4);
        rst = 1'b1;
        @(negedge clk);
        idle_chk("midrst");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        start0 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            start0 = 1'b0;
            n++;
        end while (cpu_rst0 && n < 10);
        chk("latency", n, 3);
        chk("latency.cycles0", cyc0, 0);
        chk("latency.busy", busy0, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Random runs against a model derived from the run rules
        for (int i = 0; i < 16; i++) begin
            h    = ($urandom_range(0, 3) == 0) ? $urandom_range(95, 110) : $urandom_range(0, 100);
            sd   = 8'($urandom);
            st   = 8'($urandom);
            a    = 5'($urandom);
            memv = 8'($urandom);
            acc_h = 8'(int'(sd) + int'(st) * (h - 1));
            ea   = $urandom_range(0, 3) != 0 ? acc_h : 8'($urandom);
            em   = $urandom_range(0, 3) != 0 ? memv : memv ^ 8'($urandom_range(1, 255));
            if (h >= 1 && h <= 100) begin
                xc = h; xt = 0; xp = (acc_h == ea) && (memv == em);
            end else begin
                xc = 100; xt = 1; xp = 0;
            end
            run(0, h, sd, st, a, memv, ea, em, $urandom_range(0, 1) != 0, xc, xp, xt,
                $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
